// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock-enable / divided-clock generator with glitch-free
// divisor updates at period boundaries and a start/stop sequencer.
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10,
    parameter int MIN_DIV     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             clko,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] div_nx;
    logic [CNT_W-1:0] pend_div, pend_nx;
    logic             pend_valid, pend_valid_nx;
    logic             ready_nx, err_nx, tick_nx, clko_nx, busy_nx;
    logic             wrap;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nx      = state;
        cnt_nx        = cnt;
        div_nx        = cur_div;
        pend_nx       = pend_div;
        pend_valid_nx = pend_valid;
        ready_nx      = cfg_ready;
        err_nx        = 1'b0;
        wrap          = (state != IDLE) && (cnt == cur_div - CNT_W'(1));

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (en) state_nx = RUN;
            end
            RUN: begin
                cnt_nx = wrap ? '0 : cnt + CNT_W'(1);
                if (!en) state_nx = STOPPING;
            end
            STOPPING: begin
                cnt_nx = wrap ? '0 : cnt + CNT_W'(1);
                if (en)        state_nx = RUN;
                else if (wrap) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // A pending divisor blocks cfg_ready, so it can never collide with a new accept.
        if (wrap && pend_valid) begin
            div_nx        = pend_div;
            pend_valid_nx = 1'b0;
            ready_nx      = 1'b1;
        end

        if (cfg_valid && cfg_ready) begin
            if (cfg_div < CNT_W'(MIN_DIV)) begin
                err_nx = 1'b1;
            end else if (state == IDLE) begin
                div_nx = cfg_div;
            end else begin
                pend_nx       = cfg_div;
                pend_valid_nx = 1'b1;
                ready_nx      = 1'b0;
            end
        end

        // Outputs are registered, so they are derived from next-cycle count and divisor.
        busy_nx = (state_nx != IDLE);
        tick_nx = busy_nx && (cnt_nx == div_nx - CNT_W'(1));
        clko_nx = busy_nx && (cnt_nx >= (div_nx >> 1));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_div    <= CNT_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
            tick       <= 1'b0;
            clko       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cur_div    <= div_nx;
            pend_div   <= pend_nx;
            pend_valid <= pend_valid_nx;
            cfg_ready  <= ready_nx;
            cfg_err    <= err_nx;
            tick       <= tick_nx;
            clko       <= clko_nx;
            busy       <= busy_nx;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: per-cycle expectations are queued from the
// intended period structure and popped/compared one clock after each edge.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = '0;
    logic        cfg_ready, cfg_err, tick, clko, busy;
    logic [15:0] cur_div;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        tick;
        logic        clko;
        logic        busy;
        logic        rdy;
        logic        err;
        logic [15:0] div;
    } exp_t;

    exp_t sb[$];

    clk_div_ctrl #(.CNT_W(16), .DEFAULT_DIV(10), .MIN_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .clko      (clko),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic t, input logic c, input logic b,
                        input logic r, input logic e, input logic [15:0] d);
        exp_t x;
        x.tick = t; x.clko = c; x.busy = b; x.rdy = r; x.err = e; x.div = d;
        sb.push_back(x);
    endtask

    // Cycles from..to of a running period of length n.
    task automatic seg(input int n, input int from, input int to, input logic rdy,
                       input logic [15:0] d, input logic err_first);
        for (int i = from; i <= to; i++)
            push(i == n - 1, i >= n / 2, 1'b1, rdy, err_first && (i == from), d);
    endtask

    task automatic idle(input int k, input logic [15:0] d);
        for (int i = 0; i < k; i++) push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic step1();
        exp_t x;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_underflow cycle=%0d got=empty expected=entry", cyc);
        end else begin
            x = sb.pop_front();
            check("tick",      tick,      x.tick);
            check("clko",      clko,      x.clko);
            check("busy",      busy,      x.busy);
            check("cfg_ready", cfg_ready, x.rdy);
            check("cfg_err",   cfg_err,   x.err);
            check("cur_div",   cur_div,   x.div);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) step1();
    endtask

    initial begin
        // Reset with en held, then run N=10.
        idle(1, 10);
        drain();
        reset = 1'b0;
        en    = 1'b1;
        seg(10, 0, 9, 1'b1, 10, 1'b0);
        seg(10, 0, 9, 1'b1, 10, 1'b0);
        drain();

        // Offer 4 at cnt=2: current period completes, then 4-cycle periods.
        seg(10, 0, 2, 1'b1, 10, 1'b0);
        drain();
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        seg(10, 3, 9, 1'b0, 10, 1'b0);
        seg(4, 0, 3, 1'b1, 4, 1'b0);
        seg(4, 0, 3, 1'b1, 4, 1'b0);
        step1();
        cfg_valid = 1'b0;
        drain();

        // Illegal divisors 1 and 0 are rejected with a one-cycle error.
        cfg_valid = 1'b1;
        cfg_div   = 16'd1;
        seg(4, 0, 3, 1'b1, 4, 1'b1);
        step1();
        cfg_valid = 1'b0;
        drain();
        cfg_valid = 1'b1;
        cfg_div   = 16'd0;
        seg(4, 0, 3, 1'b1, 4, 1'b1);
        step1();
        cfg_valid = 1'b0;
        drain();

        // Back to N=10, offered at cnt=0 of a 4-cycle period.
        seg(4, 0, 0, 1'b1, 4, 1'b0);
        drain();
        cfg_valid = 1'b1;
        cfg_div   = 16'd10;
        seg(4, 1, 3, 1'b0, 4, 1'b0);
        seg(10, 0, 9, 1'b1, 10, 1'b0);
        step1();
        cfg_valid = 1'b0;
        drain();

        // Drop en at cnt=3: period finishes with its tick, then IDLE.
        seg(10, 0, 3, 1'b1, 10, 1'b0);
        drain();
        en = 1'b0;
        seg(10, 4, 9, 1'b1, 10, 1'b0);
        idle(3, 10);
        drain();

        // Drop en at cnt=3, re-raise at cnt=6: no gap.
        en = 1'b1;
        seg(10, 0, 3, 1'b1, 10, 1'b0);
        drain();
        en = 1'b0;
        seg(10, 4, 6, 1'b1, 10, 1'b0);
        drain();
        en = 1'b1;
        seg(10, 7, 9, 1'b1, 10, 1'b0);
        seg(10, 0, 0, 1'b1, 10, 1'b0);
        drain();
        en = 1'b0;
        seg(10, 1, 9, 1'b1, 10, 1'b0);
        idle(2, 10);
        drain();

        // Load 3 while IDLE, then run: 1 low / 2 high.
        cfg_valid = 1'b1;
        cfg_div   = 16'd3;
        idle(1, 3);
        step1();
        cfg_valid = 1'b0;
        en        = 1'b1;
        for (int p = 0; p < 3; p++) seg(3, 0, 2, 1'b1, 3, 1'b0);
        drain();

        // Pending 6 discarded by a mid-period reset.
        seg(3, 0, 0, 1'b1, 3, 1'b0);
        drain();
        cfg_valid = 1'b1;
        cfg_div   = 16'd6;
        seg(3, 1, 1, 1'b0, 3, 1'b0);
        step1();
        cfg_valid = 1'b0;
        reset     = 1'b1;
        idle(1, 10);
        step1();
        reset = 1'b0;
        seg(10, 0, 9, 1'b1, 10, 1'b0);
        seg(10, 0, 9, 1'b1, 10, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
